// File: rtl/dram_fifo_pkg.sv
// Shared sizing and pointer/level types for the 32-deep distributed-RAM FIFO.
package dram_fifo_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int LVL_W  = 6;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LVL_W-1:0]  lvl_t;

    localparam lvl_t LVL_FULL = lvl_t'(DEPTH);

endpackage

// File: rtl/dram_32xw.sv
// WIDTH parallel 32x1 dual-port RAMs: synchronous write at a, asynchronous read at dpra.
module dram_32xw
    import dram_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  addr_t            a,
    input  addr_t            dpra,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] dpo
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic mem [DEPTH];

        // NOTE: RAM storage has no reset; FIFO emptiness is tracked by the controller's level.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[a] <= d[b];
            end
        end

        assign dpo[b] = mem[dpra];
    end

endmodule

// File: rtl/dram_fifo32_ctrl.sv
// 32-deep first-word-fall-through FIFO: pointer, level and flag control around dram_32xw.
module dram_fifo32_ctrl
    import dram_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int AFULL_THR = 28
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [WIDTH-1:0] S_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [WIDTH-1:0] M_DATA,
    output lvl_t             LEVEL,
    output logic             ALMOST_FULL
);

    addr_t wr_ptr;
    addr_t rd_ptr;
    lvl_t  level;
    logic  push;
    logic  pop;

    // Flags decode only registered level (plus reset), so there is no ready->ready or valid->valid path.
    assign S_READY     = !RST && (level != LVL_FULL);
    assign M_VALID     = !RST && (level != '0);
    assign ALMOST_FULL = (level >= lvl_t'(AFULL_THR));
    assign LEVEL       = level;

    assign push = S_VALID && S_READY;
    assign pop  = M_VALID && M_READY;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    dram_32xw #(
        .WIDTH(WIDTH)
    ) u_ram (
        .clk  (CLK),
        .we   (push),
        .a    (wr_ptr),
        .dpra (rd_ptr),
        .d    (S_DATA),
        .dpo  (M_DATA)
    );

endmodule

// File: tb/tb_dram_fifo32_ctrl.sv
// Scoreboard bench: driver queues expected words on accepted pushes, monitor compares on pops.
module tb_dram_fifo32_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       S_VALID = 1'b0;
    logic       S_READY;
    logic [7:0] S_DATA = '0;
    logic       M_VALID;
    logic       M_READY = 1'b0;
    logic [7:0] M_DATA;
    logic [5:0] LEVEL;
    logic       ALMOST_FULL;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    int         m_lvl    = 0;
    logic [7:0] sb[$];

    always #5 CLK = ~CLK;

    dram_fifo32_ctrl #(
        .WIDTH     (8),
        .AFULL_THR (28)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .S_VALID     (S_VALID),
        .S_READY     (S_READY),
        .S_DATA      (S_DATA),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .M_DATA      (M_DATA),
        .LEVEL       (LEVEL),
        .ALMOST_FULL (ALMOST_FULL)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"},  32'(LEVEL),       32'(m_lvl));
        check({tag, "_mvalid"}, 32'(M_VALID),     32'(m_lvl != 0));
        check({tag, "_sready"}, 32'(S_READY),     32'(m_lvl != 32));
        check({tag, "_afull"},  32'(ALMOST_FULL), 32'(m_lvl >= 28));
    endtask

    // Handshakes are stable from just after one edge to the next, so the negedge sees the pending transfer.
    always @(negedge CLK) begin
        if (!RST && M_VALID && M_READY) begin
            if (sb.size() == 0) begin
                check("pop_unexpected_mvalid", 32'(M_VALID), 32'd0);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                check("pop_data", 32'(M_DATA), 32'(exp));
            end
        end
    end

    task automatic cycle(input string tag, input logic sv, input logic [7:0] sd, input logic mr);
        bit push;
        bit pop;
        S_VALID = sv;
        S_DATA  = sd;
        M_READY = mr;
        push = sv && (m_lvl != 32);
        pop  = mr && (m_lvl != 0);
        if (push) sb.push_back(sd);
        @(posedge CLK);
        #1;
        m_lvl = m_lvl + int'(push) - int'(pop);
        check_status(tag);
    endtask

    task automatic do_reset(input int n, input logic sv, input logic [7:0] sd);
        RST     = 1'b1;
        S_VALID = sv;
        S_DATA  = sd;
        M_READY = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
            check("rst_sready", 32'(S_READY), 32'd0);
            check("rst_mvalid", 32'(M_VALID), 32'd0);
        end
        RST     = 1'b0;
        S_VALID = 1'b0;
        M_READY = 1'b0;
        sb.delete();
        m_lvl = 0;
        #1;
        check_status("post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1: reset
        do_reset(2, 1'b0, 8'h00);

        // 2: single word falls through after its push edge
        cycle("t2_push", 1'b1, 8'hA5, 1'b0);
        check("t2_head", 32'(M_DATA), 32'h0000_00A5);
        cycle("t2_pop", 1'b0, 8'h00, 1'b1);

        // 3: fill, hold a rejected word, then drain in order
        for (int i = 0; i < 32; i++) begin
            cycle("t3_fill", 1'b1, 8'(i), 1'b0);
            if (i == 26) check("t3_afull_27", 32'(ALMOST_FULL), 32'd0);
            if (i == 27) check("t3_afull_28", 32'(ALMOST_FULL), 32'd1);
        end
        repeat (3) cycle("t3_hold", 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 32; i++) cycle("t3_drain", 1'b0, 8'h00, 1'b1);

        // 4: streaming at level 5 across three pointer wraps
        for (int i = 0; i < 5; i++) cycle("t4_prime", 1'b1, 8'(i), 1'b0);
        for (int i = 5; i < 105; i++) cycle("t4_stream", 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 5; i++) cycle("t4_drain", 1'b0, 8'h00, 1'b1);

        // 5: push and pop together while full -> only the pop happens
        for (int i = 0; i < 32; i++) cycle("t5_fill", 1'b1, 8'(8'h40 + i), 1'b0);
        cycle("t5_both", 1'b1, 8'h77, 1'b1);
        cycle("t5_accept", 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 32; i++) cycle("t5_drain", 1'b0, 8'h00, 1'b1);

        // 6: reset with 12 words stored; a push held during reset must be ignored
        for (int i = 0; i < 12; i++) cycle("t6_fill", 1'b1, 8'(8'h80 + i), 1'b0);
        do_reset(1, 1'b1, 8'hEE);
        cycle("t6_push", 1'b1, 8'h3C, 1'b0);
        check("t6_head", 32'(M_DATA), 32'h0000_003C);
        cycle("t6_pop", 1'b0, 8'h00, 1'b1);

        #2;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
